// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard/stall signal bundle between the ID-stage sequencer and the pipeline
//   slave  (sequencer side): hazard sources in; PC, IF/ID and ID/EX controls and statistics out
//   master (pipeline side):  the mirror image of slave
interface hazard_stall_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        br_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic        timeout_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, timeout_err,
               stall_cycles, flush_count
    );
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, timeout_err,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubbles, data-memory freeze and branch flush sequencer for a 5-stage MIPS pipe
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   hz (slave)      id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rt, br_taken, dmem_req/dmem_ready in;
//                   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, timeout_err,
//                   stall_cycles[31:0], flush_count[15:0] out
//   LOAD_STALL_CYC  bubbles per load-use hazard (1..15)
//   MEM_TIMEOUT     MEM_WAIT cycles before a forced release (1..255)
//   HAZARD_STATS_EN define to build the stall/flush statistics counters; otherwise they read 0
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
    localparam logic [7:0] BUB_LAST  = 8'(LOAD_STALL_CYC - 1);
    localparam logic [7:0] WAIT_MAX  = 8'(MEM_TIMEOUT);
    localparam bit         MULTI_BUB = LOAD_STALL_CYC > 1;
    state_t     state, state_nx;
    logic [7:0] bub_cnt, bub_cnt_nx, wait_cnt, wait_cnt_nx;
    logic       terr, terr_set;
    logic       lu_hz, mem_hz;
    logic       pc_w, ifid_w, flush, bubble, freeze;
    assign lu_hz  = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
                    ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
    assign mem_hz = hz.dmem_req & ~hz.dmem_ready;
    always_comb begin
        state_nx    = state;
        bub_cnt_nx  = bub_cnt;
        wait_cnt_nx = wait_cnt;
        terr_set    = 1'b0;
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        flush       = 1'b0;
        bubble      = 1'b0;
        freeze      = 1'b0;
        case (state)
            RUN: begin
                if (mem_hz) begin
                    pc_w        = 1'b0;
                    ifid_w      = 1'b0;
                    freeze      = 1'b1;
                    wait_cnt_nx = 8'd1;
                    state_nx    = MEM_WAIT;
                end else if (lu_hz) begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    bubble     = 1'b1;
                    bub_cnt_nx = 8'd1;
                    state_nx   = MULTI_BUB ? LU_STALL : RUN;
                end else
                    flush = hz.br_taken;
            end
            LU_STALL: begin
                // A memory stall here means the load already left EX, so remaining bubbles are dropped.
                if (mem_hz) begin
                    pc_w        = 1'b0;
                    ifid_w      = 1'b0;
                    freeze      = 1'b1;
                    wait_cnt_nx = 8'd1;
                    state_nx    = MEM_WAIT;
                end else begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    bubble     = 1'b1;
                    bub_cnt_nx = bub_cnt + 8'(bub_cnt != 8'hff);
                    state_nx   = (bub_cnt == BUB_LAST) ? RUN : LU_STALL;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready)
                    state_nx = RUN;
                else if (wait_cnt == WAIT_MAX) begin
                    terr_set = 1'b1;
                    state_nx = RUN;
                end else begin
                    pc_w        = 1'b0;
                    ifid_w      = 1'b0;
                    freeze      = 1'b1;
                    wait_cnt_nx = wait_cnt + 8'(wait_cnt != 8'hff);
                end
            end
            default: state_nx = RUN;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            bub_cnt  <= '0;
            wait_cnt <= '0;
            terr     <= 1'b0;
        end else begin
            state    <= state_nx;
            bub_cnt  <= bub_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            terr     <= terr | terr_set;
        end
    end
    // While rst is high the pipe is held and a NOP is forced into IF/ID and ID/EX.
    assign hz.pc_write    = ~rst & pc_w;
    assign hz.ifid_write  = ~rst & ifid_w;
    assign hz.ifid_flush  = rst | flush;
    assign hz.idex_bubble = rst | bubble;
    assign hz.pipe_freeze = ~rst & freeze;
    assign hz.timeout_err = terr;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_w && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (flush && flush_q != '1) flush_q <= flush_q + 16'd1;
        end
    end
    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors for hazard_stall_ctrl (dut_a: 1 bubble / 255 timeout, dut_b: 3 bubbles / 10 timeout)
module tb_hazard_stall_ctrl;
    typedef struct packed {
        logic [4:0] rs, rt, ert;
        logic       ut, mr, br, req, rdy;
    } in_t;
    typedef struct packed {
        in_t        i;
        logic [5:0] e;
    } vec_t;
    // expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, timeout_err}
    localparam logic [5:0] E_RUN = 6'b110000;
    localparam logic [5:0] E_BUB = 6'b000100;
    localparam logic [5:0] E_FL  = 6'b111000;
    localparam logic [5:0] E_FRZ = 6'b000010;
    localparam logic [5:0] E_RST = 6'b001100;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    in_t         in_a = '0, in_b = '0;
    logic [5:0]  act_a, act_b;
    logic [31:0] exp_stall [2];
    logic [15:0] exp_flush [2];
    int          checks = 0, errors = 0;
    vec_t        tab [18];
    hazard_stall_ctrl_if ia ();
    hazard_stall_ctrl_if ib ();
    hazard_stall_ctrl #(.LOAD_STALL_CYC(1), .MEM_TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .hz(ia));
    hazard_stall_ctrl #(.LOAD_STALL_CYC(3), .MEM_TIMEOUT(10))  dut_b (.clk(clk), .rst(rst), .hz(ib));
    always #5 clk = ~clk;
    assign ia.id_rs = in_a.rs;
    assign ia.id_rt = in_a.rt;
    assign ia.ex_rt = in_a.ert;
    assign ia.id_uses_rt = in_a.ut;
    assign ia.ex_mem_read = in_a.mr;
    assign ia.br_taken = in_a.br;
    assign ia.dmem_req = in_a.req;
    assign ia.dmem_ready = in_a.rdy;
    assign ib.id_rs = in_b.rs;
    assign ib.id_rt = in_b.rt;
    assign ib.ex_rt = in_b.ert;
    assign ib.id_uses_rt = in_b.ut;
    assign ib.ex_mem_read = in_b.mr;
    assign ib.br_taken = in_b.br;
    assign ib.dmem_req = in_b.req;
    assign ib.dmem_ready = in_b.rdy;
    assign act_a = {ia.pc_write, ia.ifid_write, ia.ifid_flush, ia.idex_bubble, ia.pipe_freeze, ia.timeout_err};
    assign act_b = {ib.pc_write, ib.ifid_write, ib.ifid_flush, ib.idex_bubble, ib.pipe_freeze, ib.timeout_err};
    function automatic in_t mk(input int rs, input int rt, input int ert,
                               input logic ut, input logic mr, input logic br,
                               input logic req, input logic rdy);
        in_t r;
        r.rs  = 5'(rs);
        r.rt  = 5'(rt);
        r.ert = 5'(ert);
        r.ut  = ut;
        r.mr  = mr;
        r.br  = br;
        r.req = req;
        r.rdy = rdy;
        return r;
    endfunction
    task automatic chk(input int sel, input string nm, input logic [5:0] e);
        logic [5:0] act;
        act = (sel == 0) ? act_a : act_b;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got pc/ifw/fl/bub/frz/terr=%b expected %b", nm, sel, act, e);
        end
`ifdef HAZARD_STATS_EN
        if (!rst) begin
            exp_stall[sel] = exp_stall[sel] + 32'(!e[5]);
            exp_flush[sel] = exp_flush[sel] + 16'(e[3]);
        end
`endif
    endtask
    task automatic chk_cnt(input string nm);
        checks += 4;
        if (ia.stall_cycles !== exp_stall[0] || ia.flush_count !== exp_flush[0]) begin
            errors++;
            $display("FAIL %s dut0 counters: got %0d/%0d expected %0d/%0d", nm,
                     ia.stall_cycles, ia.flush_count, exp_stall[0], exp_flush[0]);
        end
        if (ib.stall_cycles !== exp_stall[1] || ib.flush_count !== exp_flush[1]) begin
            errors++;
            $display("FAIL %s dut1 counters: got %0d/%0d expected %0d/%0d", nm,
                     ib.stall_cycles, ib.flush_count, exp_stall[1], exp_flush[1]);
        end
    endtask
    // one clock cycle: drive on the falling edge, check combinational outputs before the rising edge
    task automatic step(input int sel, input string nm, input in_t v, input logic [5:0] e);
        @(negedge clk);
        in_a = (sel == 0) ? v : '0;
        in_b = (sel == 1) ? v : '0;
        #1 chk(sel, nm, e);
    endtask
    initial begin
        in_t idle, lu8, req, rdy;
        idle = '0;
        lu8  = mk(8, 0, 8, 0, 1, 0, 0, 0);
        req  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        rdy  = mk(0, 0, 0, 0, 0, 0, 1, 1);
        exp_stall = '{32'd0, 32'd0};
        exp_flush = '{16'd0, 16'd0};
        tab[0]  = '{idle, E_RUN};
        tab[1]  = '{lu8, E_BUB};
        tab[2]  = '{idle, E_RUN};
        tab[3]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0), E_RUN};
        tab[4]  = '{mk(3, 9, 9, 1, 1, 0, 0, 0), E_BUB};
        tab[5]  = '{mk(3, 9, 9, 0, 1, 0, 0, 0), E_RUN};
        tab[6]  = '{mk(8, 0, 8, 0, 0, 0, 0, 0), E_RUN};
        tab[7]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0), E_FL};
        tab[8]  = '{mk(8, 0, 8, 0, 1, 1, 0, 0), E_BUB};
        tab[9]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0), E_FL};
        tab[10] = '{req, E_FRZ};
        tab[11] = '{rdy, E_RUN};
        tab[12] = '{idle, E_RUN};
        tab[13] = '{mk(8, 0, 8, 0, 1, 1, 1, 0), E_FRZ};
        tab[14] = '{rdy, E_RUN};
        tab[15] = '{rdy, E_RUN};
        tab[16] = '{mk(5, 6, 7, 1, 1, 0, 0, 0), E_RUN};
        tab[17] = '{idle, E_RUN};
        repeat (2) @(negedge clk);
        #1 chk(0, "reset forced", E_RST);
        chk(1, "reset forced", E_RST);
        @(negedge clk);
        rst = 1'b0;
        #1 chk(0, "reset release", E_RUN);
        chk(1, "reset release", E_RUN);
        chk_cnt("reset release");
        foreach (tab[k]) step(0, $sformatf("tab%0d", k), tab[k].i, tab[k].e);
        step(1, "t2 lu c0", lu8, E_BUB);
        step(1, "t2 lu c1", idle, E_BUB);
        step(1, "t2 lu c2", idle, E_BUB);
        step(1, "t2 lu done", idle, E_RUN);
        step(1, "t2 rt0", mk(0, 0, 0, 1, 1, 0, 0, 0), E_RUN);
        step(1, "t3 lu+br", mk(8, 0, 8, 0, 1, 1, 0, 0), E_BUB);
        step(1, "t3 br held1", mk(0, 0, 0, 0, 0, 1, 0, 0), E_BUB);
        step(1, "t3 br held2", mk(0, 0, 0, 0, 0, 1, 0, 0), E_BUB);
        step(1, "t3 br flush", mk(0, 0, 0, 0, 0, 1, 0, 0), E_FL);
        step(1, "t3 idle", idle, E_RUN);
        for (int c = 0; c < 5; c++) step(1, $sformatf("t4 freeze%0d", c), req, E_FRZ);
        step(1, "t4 ready", rdy, E_RUN);
        step(1, "t4 run", idle, E_RUN);
        step(1, "lu->mem c0", lu8, E_BUB);
        step(1, "lu->mem freeze", req, E_FRZ);
        step(1, "lu->mem ready", rdy, E_RUN);
        step(1, "lu->mem run", idle, E_RUN);
        for (int c = 0; c < 10; c++) step(1, $sformatf("t5 wait%0d", c), req, E_FRZ);
        step(1, "t5 timeout", req, E_RUN);
        step(1, "t5 sticky", idle, E_RUN | 6'b1);
        step(1, "t5 sticky lu0", lu8, E_BUB | 6'b1);
        step(1, "t5 sticky lu1", idle, E_BUB | 6'b1);
        step(1, "t5 sticky lu2", idle, E_BUB | 6'b1);
        step(1, "t5 sticky run", idle, E_RUN | 6'b1);
        step(1, "t6 wait0", req, E_FRZ | 6'b1);
        step(1, "t6 wait1", req, E_FRZ | 6'b1);
        chk_cnt("before rst");
        @(negedge clk);
        #2 rst = 1'b1;
        exp_stall = '{32'd0, 32'd0};
        exp_flush = '{16'd0, 16'd0};
        #1 chk(1, "t6 rst forced", E_RST);
        chk(0, "t6 rst forced", E_RST);
        @(negedge clk);
        rst  = 1'b0;
        in_b = '0;
        #1 chk(1, "t6 after rst", E_RUN);
        chk_cnt("t6 after rst");
        step(1, "t6 run", idle, E_RUN);
        step(1, "t6 req again", req, E_FRZ);
        step(1, "t6 ready again", rdy, E_RUN);
        step(1, "t6 final", idle, E_RUN);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
